// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared funct3 constants, state encoding and default width for the LSU
package lsu_pkg;

   localparam int LSU_ADDR_W = 5;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ERR,
      S_LOAD,
      S_WRITE,
      S_RMW_RD,
      S_RMW_WR,
      S_RESP
   } lsu_state_e;

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - byte/halfword lane extraction for loads and lane merge for sub-word stores
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [31:0] ld_word_i,
   input  logic [31:0] st_old_i,
   input  logic [15:0] st_new_i,
   input  logic [1:0]  offset_i,
   input  logic [2:0]  funct3_i,
   output logic [31:0] ld_data_o,
   output logic [31:0] st_word_o
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      byte_v    = ld_word_i[{offset_i, 3'b000} +: 8];
      half_v    = offset_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];
      ld_data_o = ld_word_i;
      case (funct3_i)
         F3_B:    ld_data_o = {{24{byte_v[7]}}, byte_v};
         F3_H:    ld_data_o = {{16{half_v[15]}}, half_v};
         F3_BU:   ld_data_o = {24'h0, byte_v};
         F3_HU:   ld_data_o = {16'h0, half_v};
         default: ld_data_o = ld_word_i;
      endcase
   end

   // Only the addressed lane changes; the rest of the old word is written back untouched.
   always_comb begin
      st_word_o = st_old_i;
      case (funct3_i[1:0])
         2'b00:   st_word_o[{offset_i, 3'b000} +: 8]    = st_new_i[7:0];
         2'b01:   st_word_o[{offset_i[1], 4'b0000} +: 16] = st_new_i;
         default: st_word_o = st_old_i;
      endcase
   end

endmodule

// File: rtl/lsu_mem_master.sv
// rtl/lsu_mem_master.sv - load/store initiator driving a word-addressed memory with read-modify-write sub-word stores
module lsu_mem_master
   import lsu_pkg::*;
#(
   parameter int ADDR_W = LSU_ADDR_W,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [31:0]       req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   lsu_state_e        state_q, state_d;
   logic              we_q;
   logic [2:0]        f3_q;
   logic [ADDR_W+1:0] addr_q;
   logic [DATA_W-1:0] wdata_q, rdata_q;
   logic              accept, misaligned, out_of_range, bad_f3, req_err;
   logic [DATA_W-1:0] ld_data, st_word;

   assign accept = req_valid && (state_q == S_IDLE);

   always_comb begin
      misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
      out_of_range = |req_addr[31:ADDR_W+2];
      bad_f3       = req_we ? (req_funct3 > F3_W)
                            : ((req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11));
      req_err      = misaligned || out_of_range || bad_f3;
   end

   lsu_lane_align u_align (
      .ld_word_i (mem_rdata),
      .st_old_i  (rdata_q),
      .st_new_i  (wdata_q[15:0]),
      .offset_i  (addr_q[1:0]),
      .funct3_i  (f3_q),
      .ld_data_o (ld_data),
      .st_word_o (st_word)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         we_q    <= 1'b0;
         f3_q    <= 3'b000;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            addr_q  <= req_addr[ADDR_W+1:0];
            wdata_q <= req_wdata;
         end
         if (state_q == S_LOAD)
            rdata_q <= ld_data;
         else if (state_q == S_RMW_RD)
            rdata_q <= mem_rdata;
      end
   end

   always_comb begin
      state_d    = state_q;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      resp_err   = 1'b0;
      resp_rdata = '0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_wdata  = '0;
      mem_addr   = addr_q[ADDR_W+1:2];
      case (state_q)
         S_IDLE: begin
            req_ready = 1'b1;
            mem_addr  = '0;
            if (req_valid) begin
               if (req_err)             state_d = S_ERR;
               else if (!req_we)        state_d = S_LOAD;
               else if (req_funct3 == F3_W) state_d = S_WRITE;
               else                     state_d = S_RMW_RD;
            end
         end
         S_ERR: begin
            resp_valid = 1'b1;
            resp_err   = 1'b1;
            mem_addr   = '0;
            state_d    = S_IDLE;
         end
         S_LOAD: begin
            mem_read = 1'b1;
            state_d  = S_RESP;
         end
         S_WRITE: begin
            mem_write = 1'b1;
            mem_wdata = wdata_q;
            state_d   = S_RESP;
         end
         S_RMW_RD: begin
            mem_read = 1'b1;
            state_d  = S_RMW_WR;
         end
         S_RMW_WR: begin
            mem_write = 1'b1;
            mem_wdata = st_word;
            state_d   = S_RESP;
         end
         S_RESP: begin
            resp_valid = 1'b1;
            if (!we_q) resp_rdata = rdata_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      // A reset cycle abandons whatever is in flight, so nothing may leave the block.
      if (reset) begin
         mem_read   = 1'b0;
         mem_write  = 1'b0;
         resp_valid = 1'b0;
         resp_err   = 1'b0;
         resp_rdata = '0;
      end
   end

endmodule

// File: tb/tb_lsu_mem_master.sv
// tb/tb_lsu_mem_master.sv - directed scoreboard bench for lsu_mem_master with a behavioural 32-word memory
module tb_lsu_mem_master;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_err, mem_read, mem_write;
   logic [31:0] resp_rdata, mem_wdata, mem_rdata;
   logic [4:0]  mem_addr;

   logic [31:0] mem [32];
   logic [32:0] exp_q [$];
   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int last_resp_cyc = 0;
   int wr_cnt = 0;

   always #5 clk = ~clk;

   lsu_mem_master #(.ADDR_W(5), .DATA_W(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   assign mem_rdata = mem[mem_addr];

   always @(posedge clk) begin
      cyc++;
      if (mem_write) mem[mem_addr] <= mem_wdata;
   end

   // Response scoreboard and strobe exclusivity monitor.
   always @(negedge clk) begin
      logic [32:0] e;
      if (mem_write) wr_cnt++;
      n_cmp++;
      assert (!(mem_read && mem_write)) else begin
         n_bad++;
         $error("FAIL strobe_excl observed rd=%0b wr=%0b expected not both", mem_read, mem_write);
      end
      if (resp_valid) begin
         last_resp_cyc = cyc;
         n_cmp++;
         assert (exp_q.size() != 0) else begin
            n_bad++;
            $error("FAIL resp_unexpected observed err=%0b data=%h expected no response", resp_err, resp_rdata);
         end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            assert ({resp_err, resp_rdata} === e) else begin
               n_bad++;
               $error("FAIL resp observed err=%0b data=%h expected err=%0b data=%h",
                      resp_err, resp_rdata, e[32], e[31:0]);
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
      int n;
      n = 0;
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = d;
      while (!req_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk("issue_wait", 32'(n < 50), 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_addr  = 32'hFFFF_FFFF;
      req_wdata = 32'h0BAD_0BAD;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("drain", exp_q.size(), 32'd0);
   endtask

   logic [31:0] bb [3];
   int w0;

   initial begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'h0;
      mem[1] <= 32'hCAFE_F00D;
      mem[8] <= 32'h0000_8080;
      reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
      req_addr = 32'h0; req_wdata = 32'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", req_ready, 1);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_mem_strobes", {mem_read, mem_write}, 0);
      chk("rst_rdata", resp_rdata, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      @(posedge clk); #1 reset = 1'b0;

      exp_q.push_back({1'b0, 32'h0});
      issue(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF);
      @(negedge clk);
      chk("sw_write", {mem_read, mem_write}, 32'b01);
      chk("sw_addr", mem_addr, 4);
      chk("sw_wdata", mem_wdata, 32'hDEAD_BEEF);
      @(negedge clk);
      chk("sw_resp_t2", resp_valid, 1);

      exp_q.push_back({1'b0, 32'hDEAD_BEEF});
      issue(1'b0, 3'b010, 32'h10, 32'h0);
      @(negedge clk);
      chk("lw_read", {mem_read, mem_write}, 32'b10);
      chk("lw_addr", mem_addr, 4);
      @(negedge clk);
      chk("lw_resp_t2", resp_valid, 1);

      exp_q.push_back({1'b0, 32'h0});
      issue(1'b1, 3'b000, 32'h12, 32'h0000_0055);
      @(negedge clk);
      chk("sb_rmw_rd", {mem_read, mem_write}, 32'b10);
      chk("sb_addr", mem_addr, 4);
      @(negedge clk);
      chk("sb_rmw_wr", {mem_read, mem_write}, 32'b01);
      chk("sb_wdata", mem_wdata, 32'hDE55_BEEF);
      chk("sb_no_resp_t2", resp_valid, 0);
      @(negedge clk);
      chk("sb_resp_t3", resp_valid, 1);

      exp_q.push_back({1'b0, 32'hDE55_BEEF});
      issue(1'b0, 3'b010, 32'h10, 32'h0); drain();
      exp_q.push_back({1'b0, 32'hFFFF_FF80});
      issue(1'b0, 3'b000, 32'h20, 32'h0); drain();
      exp_q.push_back({1'b0, 32'h0000_0080});
      issue(1'b0, 3'b100, 32'h20, 32'h0); drain();
      exp_q.push_back({1'b0, 32'hFFFF_8080});
      issue(1'b0, 3'b001, 32'h20, 32'h0); drain();
      exp_q.push_back({1'b0, 32'h0000_8080});
      issue(1'b0, 3'b101, 32'h20, 32'h0); drain();

      begin
         logic [35:0] errs [4];
         errs[0] = {1'b0, 3'b001, 32'h03};
         errs[1] = {1'b1, 3'b010, 32'h02};
         errs[2] = {1'b0, 3'b010, 32'h80};
         errs[3] = {1'b0, 3'b011, 32'h00};
         for (int i = 0; i < 4; i++) begin
            w0 = wr_cnt;
            exp_q.push_back({1'b1, 32'h0});
            issue(errs[i][35], errs[i][34:32], errs[i][31:0], 32'h1234_5678);
            @(negedge clk);
            chk("err_resp_t1", {resp_valid, resp_err}, 32'b11);
            chk("err_strobes", {mem_read, mem_write}, 0);
            @(negedge clk);
            chk("err_done", resp_valid, 0);
            chk("err_no_write", wr_cnt, w0);
         end
      end

      w0 = wr_cnt;
      issue(1'b1, 3'b001, 32'h20, 32'h0000_1234);
      reset = 1'b1;
      @(negedge clk);
      chk("rst_mid_write", mem_write, 0);
      chk("rst_mid_resp", resp_valid, 0);
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_mid_ready", req_ready, 1);
      repeat (4) @(negedge clk);
      chk("rst_mid_no_write", wr_cnt, w0);
      chk("rst_mid_mem", mem[8], 32'h0000_8080);

      bb[0] = 32'h10; bb[1] = 32'h20; bb[2] = 32'h04;
      exp_q.push_back({1'b0, 32'hDE55_BEEF});
      exp_q.push_back({1'b0, 32'h0000_8080});
      exp_q.push_back({1'b0, 32'hCAFE_F00D});
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = bb[0];
      for (int k = 0; k < 3; k++) begin
         int n;
         n = 0;
         @(negedge clk);
         while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
         end
         chk("b2b_wait", 32'(n < 20), 32'd1);
         if (k > 0) chk("b2b_accept_cyc", cyc, last_resp_cyc + 1);
         @(posedge clk); #1;
         if (k < 2) req_addr = bb[k+1];
         else req_valid = 1'b0;
         @(negedge clk);
         chk("b2b_busy", req_ready, 0);
      end
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store initiator that sits between the execute stage and the word-addressed data memory (MemRead/MemWrite/addr/write_data/read_data interface, 32 words, combinational read).
- Accepts one RISC-V load/store per handshake and converts its byte address into a memory word index.
- Performs byte/halfword extraction with sign or zero extension.
- Builds sub-word stores as read-modify-write, because the memory has no byte enables.
- Flags misaligned, out-of-range and illegal-funct3 accesses without touching memory.

Parameters:
- ADDR_W, 5, memory word-index width; the byte address space is 2^(ADDR_W+2) bytes.
- DATA_W, 32, data width; fixed at 32, other values are unsupported.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  pipeline presents a request.
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid and req_ready are both high.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3 (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the low byte or halfword is used for SB/SH.
- resp_valid  out  1  one-cycle pulse that completes the accepted request.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_err  out  1  valid with resp_valid: misaligned, out-of-range or illegal funct3.
- mem_read  out  1  to memory MemRead.
- mem_write  out  1  to memory MemWrite.
- mem_addr  out  ADDR_W  word index, req_addr[ADDR_W+1:2].
- mem_wdata  out  32  to memory write_data.
- mem_rdata  in  32  from memory read_data, combinational.

Behaviour:
- Reset values: state IDLE; req_ready=1; resp_valid, resp_err, mem_read, mem_write = 0; resp_rdata, mem_addr, mem_wdata = 0.
- Reset asserted in any state forces IDLE on the next edge. The in-flight request is dropped: no resp_valid is produced, and mem_write is 0 during the reset cycle.
- On accept (cycle T), latch we, funct3, addr and wdata. Later changes on the req_* inputs are ignored.
- Error check at accept:
  - misaligned: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0;
  - out of range: addr[31:ADDR_W+2]≠0;
  - illegal funct3: load funct3 ∈ {011,110,111}, or store funct3 > 010.
- States:
  - IDLE: accept → ERR, LOAD, WRITE (SW) or RMW_RD (SB/SH).
  - ERR: resp_valid=1, resp_err=1, resp_rdata=0 at T+1 → IDLE. No memory strobe is ever issued.
  - LOAD (T+1): mem_read=1; capture the extracted/extended mem_rdata in a register → RESP.
  - RESP (T+2 for loads/SW, T+3 for SB/SH): resp_valid=1 → IDLE.
  - WRITE (T+1): mem_write=1, mem_wdata=wdata → RESP.
  - RMW_RD (T+1): mem_read=1; capture mem_rdata → RMW_WR.
  - RMW_WR (T+2): mem_write=1, mem_wdata = captured word with the byte/halfword lane addr[1:0] replaced → RESP.
- Load extraction selects the lane by addr[1:0]. LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
- Latency (accept to resp_valid): load 2, SW 2, SB/SH 3, error 1.
- req_ready is low in every non-IDLE state. A new accept is possible the cycle after resp_valid.
- mem_read and mem_write are never high in the same cycle. Both are decoded only from the registered state, so they are glitch-free.
- mem_addr holds the latched word index from T+1 until the RESP cycle; it is 0 in IDLE.

Decomposition:
- Shared package lsu_pkg:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - state encoding (IDLE, ERR, LOAD, WRITE, RMW_RD, RMW_WR, RESP);
  - ADDR_W default.
- One combinational sub-module, lsu_lane_align, holding the pure datapath:
  - load extract plus sign/zero extend, given (word, offset, funct3);
  - store merge, given (old word, new data, offset, funct3).

Test Plan:
- SW 0xDEADBEEF @0x10, then LW @0x10 → mem_write at T+1 with mem_addr=4; LW resp_rdata=0xDEADBEEF at T+2, resp_err=0.
- Word @0x10 = 0xDEADBEEF, SB wdata=0x55 @0x12 → RMW_RD at T+1, mem_write at T+2 with mem_wdata=0xDE55BEEF, resp_valid at T+3.
- Word @0x20 = 0x00008080:
  - LB @0x20 → 0xFFFFFF80;
  - LBU @0x20 → 0x00000080;
  - LH @0x20 → 0xFFFF8080;
  - LHU @0x20 → 0x00008080.
- Error cases → resp_err=1 at T+1, resp_rdata=0, and mem_read/mem_write stay 0 throughout:
  - LH @0x03;
  - SW @0x02;
  - LW @0x80 (out of range);
  - load funct3=011.
- SH issued, reset asserted at T+1 (during RMW_RD) → no mem_write in any cycle, no resp_valid, req_ready=1 the cycle after reset.
- req_valid held high across three back-to-back LWs → req_ready is low while busy, each request is accepted the cycle after the previous resp_valid, and responses arrive in order.
